// File: rtl/sb_coinc_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : sb_coinc_trigger
//  Description : Three-channel threshold discriminator with an N-of-3
//                coincidence, an edge-triggered one-clock TRIG, a holdoff /
//                re-arm state machine and a saturating trigger counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sb_coinc_trigger #(
    parameter int ADC_WIDTH = 12,
    parameter int HOLDOFF   = 8,
    parameter int CNT_WIDTH = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [ADC_WIDTH-1:0] ADC0,
    input  logic [ADC_WIDTH-1:0] ADC1,
    input  logic [ADC_WIDTH-1:0] ADC2,
    input  logic [ADC_WIDTH-1:0] THRES0,
    input  logic [ADC_WIDTH-1:0] THRES1,
    input  logic [ADC_WIDTH-1:0] THRES2,
    input  logic [2:0]           PMT_MASK,
    input  logic [1:0]           COINC_LEVEL,
    input  logic                 CLR_COUNT,
    output logic                 TRIG,
    output logic [2:0]           TRIG_PMTS,
    output logic [CNT_WIDTH-1:0] TRIG_COUNT,
    output logic                 BUSY
);

    localparam int                   c_HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_HO_W-1:0]    c_HO_LOAD = c_HO_W'(HOLDOFF - 1);
    localparam logic [c_HO_W-1:0]    c_HO_ONE  = c_HO_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [0:0] c_ST_ARMED = 1'b0;
    localparam logic [0:0] c_ST_HOLD  = 1'b1;

    logic [ADC_WIDTH-1:0] w_adc [3];
    logic [ADC_WIDTH-1:0] w_thr [3];

    assign w_adc[0] = ADC0;
    assign w_adc[1] = ADC1;
    assign w_adc[2] = ADC2;
    assign w_thr[0] = THRES0;
    assign w_thr[1] = THRES1;
    assign w_thr[2] = THRES2;

    // Stage 1: input capture
    logic [ADC_WIDTH-1:0] r_adc [3];
    logic [ADC_WIDTH-1:0] r_thr [3];
    logic [2:0]           r_mask1;
    logic [1:0]           r_level1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                r_adc[i] <= '0;
                r_thr[i] <= '0;
            end
            r_mask1  <= '0;
            r_level1 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_adc[i] <= w_adc[i];
                r_thr[i] <= w_thr[i];
            end
            r_mask1  <= PMT_MASK;
            r_level1 <= COINC_LEVEL;
        end
    end

    // Stage 2: strict unsigned per-channel discrimination
    logic [2:0] w_over;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign w_over[gi] = (r_adc[gi] > r_thr[gi]) & r_mask1[gi];
    end

    logic [2:0] r_over2;
    logic [1:0] r_level2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_over2  <= '0;
            r_level2 <= '0;
        end else begin
            r_over2  <= w_over;
            r_level2 <= r_level1;
        end
    end

    // Stage 3: multiplicity; the over pattern travels alongside coinc
    logic [1:0] w_pop;
    logic       w_coinc;

    assign w_pop   = 2'(r_over2[0]) + 2'(r_over2[1]) + 2'(r_over2[2]);
    assign w_coinc = (r_level2 != 2'd0) && (w_pop >= r_level2);

    logic       r_coinc3;
    logic [2:0] r_over3;
    logic       r_coinc_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_coinc3     <= 1'b0;
            r_over3      <= '0;
            r_coinc_prev <= 1'b0;
        end else begin
            r_coinc3     <= w_coinc;
            r_over3      <= r_over2;
            r_coinc_prev <= r_coinc3;
        end
    end

    logic w_rise;
    assign w_rise = r_coinc3 & ~r_coinc_prev;

    // FSM: state register
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_HO_W-1:0] r_hold_cnt;
    logic [c_HO_W-1:0] w_hold_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= c_ST_ARMED;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // FSM: next state; re-arm needs both the holdoff expired and coinc low
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        if (!ENABLE) begin
            w_state_nxt = c_ST_ARMED;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                c_ST_ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = c_ST_HOLD;
                        w_hold_nxt  = c_HO_LOAD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold_cnt != '0) begin
                        w_hold_nxt = r_hold_cnt - c_HO_ONE;
                    end else if (!r_coinc3) begin
                        w_state_nxt = c_ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_ARMED;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // FSM: outputs
    logic w_fire;
    logic w_busy;

    always_comb begin
        w_fire = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_ST_ARMED: w_fire = ENABLE & w_rise;
            c_ST_HOLD:  w_busy = 1'b1;
            default:    w_busy = 1'b0;
        endcase
    end

    assign BUSY = w_busy;

    logic                 r_trig;
    logic [2:0]           r_trig_pmts;
    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_trig      <= 1'b0;
            r_trig_pmts <= '0;
        end else begin
            r_trig <= w_fire;
            if (w_fire) begin
                r_trig_pmts <= r_over3;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (CLR_COUNT) begin
            r_count <= '0;
        end else if (w_fire && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + c_CNT_ONE;
        end
    end

    assign TRIG       = r_trig;
    assign TRIG_PMTS  = r_trig_pmts;
    assign TRIG_COUNT = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sb_coinc_trigger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sb_coinc_trigger
//  Description : Self-checking bench: vector table, corner sequences and a
//                randomized run against a cycle-indexed reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sb_coinc_trigger;

    localparam int AW  = 12;
    localparam int HO  = 8;
    localparam int CW  = 24;
    localparam int CW4 = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ENABLE = 1'b0;
    logic [AW-1:0] ADC0 = '0, ADC1 = '0, ADC2 = '0;
    logic [AW-1:0] THRES0 = '0, THRES1 = '0, THRES2 = '0;
    logic [2:0]    PMT_MASK = '0;
    logic [1:0]    COINC_LEVEL = '0;
    logic          CLR_COUNT = 1'b0;

    logic          TRIG, BUSY, TRIG4, BUSY4;
    logic [2:0]    TRIG_PMTS, TRIG_PMTS4;
    logic [CW-1:0] TRIG_COUNT;
    logic [CW4-1:0] TRIG_COUNT4;

    always #5 CLK = ~CLK;

    sb_coinc_trigger #(.ADC_WIDTH(AW), .HOLDOFF(HO), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .ADC0(ADC0), .ADC1(ADC1), .ADC2(ADC2),
        .THRES0(THRES0), .THRES1(THRES1), .THRES2(THRES2),
        .PMT_MASK(PMT_MASK), .COINC_LEVEL(COINC_LEVEL), .CLR_COUNT(CLR_COUNT),
        .TRIG(TRIG), .TRIG_PMTS(TRIG_PMTS), .TRIG_COUNT(TRIG_COUNT), .BUSY(BUSY)
    );

    sb_coinc_trigger #(.ADC_WIDTH(AW), .HOLDOFF(HO), .CNT_WIDTH(CW4)) dut4 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .ADC0(ADC0), .ADC1(ADC1), .ADC2(ADC2),
        .THRES0(THRES0), .THRES1(THRES1), .THRES2(THRES2),
        .PMT_MASK(PMT_MASK), .COINC_LEVEL(COINC_LEVEL), .CLR_COUNT(CLR_COUNT),
        .TRIG(TRIG4), .TRIG_PMTS(TRIG_PMTS4), .TRIG_COUNT(TRIG_COUNT4), .BUSY(BUSY4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-sample coincidence history indexed by edge number
    typedef struct packed {
        logic       c;
        logic [2:0] o;
    } samp_t;

    samp_t   hist[$];
    bit      m_armed;
    bit      m_trig;
    logic [2:0] m_pmts;
    longint  m_cnt, m_cnt4;
    longint  m_edge, m_trig_edge;

    function automatic samp_t sample_now();
        samp_t s;
        int n;
        s.o[0] = (ADC0 > THRES0) && PMT_MASK[0];
        s.o[1] = (ADC1 > THRES1) && PMT_MASK[1];
        s.o[2] = (ADC2 > THRES2) && PMT_MASK[2];
        n = int'(s.o[0]) + int'(s.o[1]) + int'(s.o[2]);
        s.c = (COINC_LEVEL != 0) && (n >= int'(COINC_LEVEL));
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back('0);
        m_armed = 1; m_trig = 0; m_pmts = '0;
        m_cnt = 0; m_cnt4 = 0; m_edge = 0; m_trig_edge = -1000;
    endtask

    // Decision at edge e concerns the sample presented three edges earlier
    task automatic model_edge();
        samp_t d, p;
        m_edge++;
        hist.push_back(sample_now());
        d = hist[hist.size()-4];
        p = hist[hist.size()-5];
        m_trig = 0;
        if (!ENABLE) begin
            m_armed = 1;
        end else if (m_armed) begin
            if (d.c && !p.c) begin
                m_trig = 1; m_pmts = d.o; m_armed = 0; m_trig_edge = m_edge;
            end
        end else if ((m_edge - m_trig_edge) >= HO && !d.c) begin
            m_armed = 1;
        end
        if (CLR_COUNT) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (m_trig) begin
            if (m_cnt  < (64'd1 << CW)  - 1) m_cnt++;
            if (m_cnt4 < (64'd1 << CW4) - 1) m_cnt4++;
        end
        while (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("TRIG",        TRIG,        m_trig);
        chk("TRIG_PMTS",   TRIG_PMTS,   m_pmts);
        chk("TRIG_COUNT",  TRIG_COUNT,  m_cnt);
        chk("BUSY",        BUSY,        !m_armed);
        chk("TRIG4",       TRIG4,       m_trig);
        chk("TRIG_COUNT4", TRIG_COUNT4, m_cnt4);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_TRIG",  TRIG, 0);
        chk("rst_PMTS",  TRIG_PMTS, 0);
        chk("rst_COUNT", TRIG_COUNT, 0);
        chk("rst_BUSY",  BUSY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic set_idle();
        ADC0 = 0; ADC1 = 0; ADC2 = 0;
        THRES0 = 100; THRES1 = 100; THRES2 = 100;
        PMT_MASK = 3'b111; COINC_LEVEL = 2'd1;
        ENABLE = 1'b1; CLR_COUNT = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] a0, a1, a2, t0, t1, t2;
        logic [2:0]    mask;
        logic [1:0]    lvl;
        logic          fire;
        logic [2:0]    pmts;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_vec(input int idx, input vec_t v);
        ADC0 = v.a0; ADC1 = v.a1; ADC2 = v.a2;
        THRES0 = v.t0; THRES1 = v.t1; THRES2 = v.t2;
        PMT_MASK = v.mask; COINC_LEVEL = v.lvl;
        step();
        ADC0 = 0; ADC1 = 0; ADC2 = 0;
        step();
        step();
        chk($sformatf("vec%0d_early", idx), TRIG, 0);
        step();
        chk($sformatf("vec%0d_trig", idx), TRIG, v.fire);
        if (v.fire) chk($sformatf("vec%0d_pmts", idx), TRIG_PMTS, v.pmts);
        set_idle();
        repeat (12) step();
    endtask

    int trig_n, busy_n;

    initial begin
        //          a0    a1    a2    t0    t1    t2    mask    lvl fire pmts
        vecs[0]  = '{200,    0,    0,  100,  100,  100, 3'b111, 1, 1, 3'b001};
        vecs[1]  = '{100,  100,  150,  100,  100,  100, 3'b111, 2, 0, 3'b000};
        vecs[2]  = '{100,  101,  150,  100,  100,  100, 3'b111, 2, 1, 3'b110};
        vecs[3]  = '{500,  500,  500,  100,  100,  100, 3'b011, 3, 0, 3'b000};
        vecs[4]  = '{500,  500,  500,  100,  100,  100, 3'b111, 0, 0, 3'b000};
        vecs[5]  = '{500,  500,  500,  100,  100,  100, 3'b111, 3, 1, 3'b111};
        vecs[6]  = '{0,   4095, 4095,  100, 4094, 4094, 3'b110, 2, 1, 3'b110};
        vecs[7]  = '{101,    0,    0,  100,  100,  100, 3'b110, 1, 0, 3'b000};
        vecs[8]  = '{4095, 4095, 4095, 4095, 4095, 4095, 3'b111, 1, 0, 3'b000};
        vecs[9]  = '{1,      0,    0,    0,  100,  100, 3'b001, 1, 1, 3'b001};
        vecs[10] = '{50,    60,   70,   49,   60,   69, 3'b111, 2, 1, 3'b101};
        vecs[11] = '{50,    60,   70,   49,   60,   69, 3'b111, 3, 0, 3'b000};

        set_idle();
        model_reset();
        do_reset();

        // Idle: nothing fires
        repeat (50) step();
        chk("idle_count", TRIG_COUNT, 0);
        chk("idle_busy",  BUSY, 0);

        // Single-cycle pulse: latency, pattern, count, holdoff length
        ADC0 = 200;
        step();
        ADC0 = 0;
        step(); step();
        chk("pulse_early", TRIG, 0);
        step();
        chk("pulse_trig",  TRIG, 1);
        chk("pulse_pmts",  TRIG_PMTS, 3'b001);
        chk("pulse_count", TRIG_COUNT, 1);
        busy_n = int'(BUSY);
        trig_n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            busy_n += int'(BUSY);
            trig_n += int'(TRIG);
        end
        chk("pulse_busy_cycles", busy_n, HO);
        chk("pulse_one_cycle",   trig_n, 0);

        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // Sustained coincidence: one trigger, then edge re-trigger
        do_reset();
        set_idle();
        ADC0 = 500; ADC1 = 500; ADC2 = 500; COINC_LEVEL = 2'd3;
        trig_n = 0;
        for (int i = 0; i < 40; i++) begin step(); trig_n += int'(TRIG); end
        chk("sustain_single", trig_n, 1);
        ADC0 = 0;
        step();
        ADC0 = 500;
        trig_n = 0;
        for (int i = 0; i < 10; i++) begin step(); trig_n += int'(TRIG); end
        chk("sustain_retrig", trig_n, 1);
        chk("sustain_count",  TRIG_COUNT, 2);

        // Re-enable during sustained coinc must wait for a new edge
        ENABLE = 1'b0;
        repeat (5) step();
        chk("disable_busy", BUSY, 0);
        ENABLE = 1'b1;
        trig_n = 0;
        for (int i = 0; i < 20; i++) begin step(); trig_n += int'(TRIG); end
        chk("reenable_no_trig", trig_n, 0);
        ADC1 = 0;
        step();
        ADC1 = 500;
        trig_n = 0;
        for (int i = 0; i < 10; i++) begin step(); trig_n += int'(TRIG); end
        chk("reenable_edge_trig", trig_n, 1);
        chk("reenable_count", TRIG_COUNT, 3);

        // Saturation of the narrow counter
        do_reset();
        set_idle();
        for (int n = 0; n < 20; n++) begin
            ADC0 = 200;
            step();
            ADC0 = 0;
            repeat (11) step();
        end
        chk("sat_count4",  TRIG_COUNT4, 15);
        chk("sat_count24", TRIG_COUNT, 20);

        // Clear on the trigger cycle wins
        ADC2 = 300;
        step();
        ADC2 = 0;
        step(); step();
        CLR_COUNT = 1'b1;
        step();
        CLR_COUNT = 1'b0;
        chk("clr_trig",   TRIG, 1);
        chk("clr_count",  TRIG_COUNT, 0);
        chk("clr_count4", TRIG_COUNT4, 0);
        repeat (12) step();

        // Async reset while in holdoff
        ADC1 = 300;
        step();
        ADC1 = 0;
        repeat (5) step();
        chk("midhold_busy", BUSY, 1);
        do_reset();
        chk("midhold_rst_busy", BUSY, 0);

        // Randomized run against the model
        set_idle();
        THRES0 = 100; THRES1 = 101; THRES2 = 99;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) >= 6) ADC0 = AW'($urandom_range(95, 105));
            if ($urandom_range(0, 9) >= 6) ADC1 = AW'($urandom_range(95, 105));
            if ($urandom_range(0, 9) >= 6) ADC2 = AW'($urandom_range(95, 105));
            if ($urandom_range(0, 49) == 0) PMT_MASK = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) COINC_LEVEL = 2'($urandom_range(0, 3));
            ENABLE    = ($urandom_range(0, 29) != 0);
            CLR_COUNT = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_coinc_trigger.md
Name: sb_coinc_trigger

Overview:
Single-bin threshold/coincidence discriminator for the three large PMT channels. It compares each ADC stream against a per-channel threshold and forms an N-of-3 coincidence. On each new coincidence it emits a one-clock TRIG pulse, which feeds the pulse-stretch stage downstream. Includes a holdoff/re-arm state machine and a saturating trigger counter for rate monitoring.

Parameters:
ADC_WIDTH, 12, width of each ADC sample and threshold
HOLDOFF, 8, minimum cycles (>=1) after a trigger before re-arm is allowed
CNT_WIDTH, 24, width of trigger counter

Ports:
CLK  input  1  sample clock (120 MHz ADC clock domain)
RST  input  1  reset, asynchronous, active-high
ENABLE  input  1  trigger enable
ADC0  input  ADC_WIDTH  PMT0 sample, unsigned
ADC1  input  ADC_WIDTH  PMT1 sample, unsigned
ADC2  input  ADC_WIDTH  PMT2 sample, unsigned
THRES0  input  ADC_WIDTH  PMT0 threshold, unsigned
THRES1  input  ADC_WIDTH  PMT1 threshold
THRES2  input  ADC_WIDTH  PMT2 threshold
PMT_MASK  input  3  bit i=1 includes PMT i
COINC_LEVEL  input  2  required channel multiplicity, 0 = disabled
CLR_COUNT  input  1  synchronous counter clear
TRIG  output  1  one-cycle trigger pulse, to stretch stage
TRIG_PMTS  output  3  over-threshold pattern captured at trigger
TRIG_COUNT  output  CNT_WIDTH  saturating trigger count
BUSY  output  1  high while not armed (HOLD state)

Behaviour:
- Reset (RST high, async): all pipeline regs 0; state ARMED; TRIG=0, TRIG_PMTS=0, TRIG_COUNT=0, BUSY=0.
- Stage 1 (edge k): register ADCx, THRESx, PMT_MASK, COINC_LEVEL.
- Stage 2 (edge k+1): over[i] = (ADCi > THRESi) & PMT_MASK[i]. Comparison is strict and unsigned; equal does not fire.
- Stage 3 (edge k+2): coinc = (COINC_LEVEL != 0) & (popcount(over) >= COINC_LEVEL). COINC_LEVEL=3 with fewer than 3 mask bits never fires.
- FSM and outputs (edge k+3). TRIG goes high on the edge 3 clocks after the sample is presented; total latency is 3 cycles.
- States:
  - ARMED: if ENABLE & coinc & !coinc_prev: TRIG=1 for exactly one cycle; TRIG_PMTS <= delayed over pattern aligned to coinc; TRIG_COUNT increments; load holdoff counter with HOLDOFF-1; go to HOLD.
  - HOLD: BUSY=1; TRIG=0; holdoff counter decrements to 0. Return to ARMED only when the counter is 0 and coinc is 0 (re-arm requires coinc to drop). A coincidence lasting longer than HOLDOFF produces only one trigger.
- coinc_prev: registered coinc, updated every cycle regardless of state. It is 0 after reset, so coinc high on the first valid cycle triggers.
- TRIG_PMTS holds its value until the next trigger.
- ENABLE low: FSM forced to ARMED with holdoff cleared; TRIG=0; pipeline keeps running; TRIG_COUNT held. Re-enabling during a sustained coinc does not trigger until coinc falls and rises again (edge rule).
- TRIG_COUNT saturates at all-ones and does not wrap.
- CLR_COUNT has priority over an increment in the same cycle: the result is 0.
- TRIG width is always 1 cycle. Pulse widening is done downstream.

Test Plan:
- Reset then idle with ADC=0, THRES=100, mask=111, level=1 -> TRIG=0, TRIG_COUNT=0, BUSY=0 for 50 cycles.
- ADC0 pulse of 200 for 1 cycle, level=1 -> TRIG high exactly 1 cycle, 3 clocks after sample; TRIG_PMTS=001; TRIG_COUNT=1; BUSY high 8 cycles.
- ADC0=ADC1=100 (equal to threshold), ADC2=150, level=2 -> no trigger. Then ADC1=101 -> one trigger, TRIG_PMTS=110... corrected pattern: TRIG_PMTS=110 (PMT1 and PMT2).
- All ADC=500 held 40 cycles, level=3, HOLDOFF=8 -> exactly one TRIG. After ADC drops for 1 cycle and rises again -> second TRIG; TRIG_COUNT=2.
- Mask=011, level=3, all ADC high -> no TRIG. COINC_LEVEL=0 with all ADC high -> no TRIG.
- CNT_WIDTH=4, 20 separated triggers -> TRIG_COUNT stops at 15. CLR_COUNT asserted on a trigger cycle -> TRIG_COUNT=0. Async RST asserted mid-HOLD -> outputs 0 immediately, state ARMED.
